// File: rtl/ram_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the RAM port arbiter.
// Optional statistics counters are enabled by defining RAM_ARB_STATS_EN.
package ram_arb_pkg;

    typedef enum logic {StInit, StRun} arb_state_e;

    localparam int unsigned DEF_AW  = 6;
    localparam int unsigned DEF_DW  = 8;
    localparam int unsigned STAT_W  = 16;
    // Widest requester vector rr_pick handles; narrower callers zero-extend.
    localparam int unsigned MAX_REQ = 4;

    // Walk upward from ptr with wrap at nreq; first valid requester wins (one-hot result).
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [1:0]         ptr,
                                                   input int unsigned        nreq);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [1:0]         idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < nreq && !found) begin
                idx = 2'((32'(ptr) + i) % nreq);
                if (valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pointer register plus combinational one-hot grant.
// Reusable for any shared resource; i_en gates all grants.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic [NREQ-1:0] i_valid,
    output logic [NREQ-1:0] o_grant
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_d;

    // Grant search starts at the pointer; never grants an invalid requester.
    always_comb begin
        o_grant = i_en ? NREQ'(rr_pick(MAX_REQ'(i_valid), 2'(r_ptr), NREQ)) : '0;
    end

    // Pointer moves just past the winner; holds when nothing is granted.
    always_comb begin
        w_ptr_d = r_ptr;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (o_grant[i]) begin
                w_ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one external single-port RAM among NREQ requesters with round-robin arbitration.
// Zero-fills the RAM after reset, then serves one access per cycle; reads return one cycle later.
// Define RAM_ARB_STATS_EN to add per-requester grant counters and a conflict counter.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = DEF_AW,
    parameter int unsigned DW   = DEF_DW
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NREQ-1:0]    i_req_valid,
    input  logic [NREQ-1:0]    i_req_we,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*DW-1:0] i_req_wdata,
    output logic [NREQ-1:0]    o_req_ready,
    output logic [NREQ-1:0]    o_rsp_valid,
    output logic [DW-1:0]      o_rsp_rdata,
    output logic               o_init_done,
    output logic               o_ram_we,
    output logic [AW-1:0]      o_ram_addr,
    output logic [DW-1:0]      o_ram_wdata,
    input  logic [DW-1:0]      i_ram_rdata
`ifdef RAM_ARB_STATS_EN
    ,
    input  logic                   i_stat_clr,
    output logic [NREQ*STAT_W-1:0] o_stat_grants,
    output logic [STAT_W-1:0]      o_stat_conflicts
`endif
);

    localparam logic [AW-1:0] CNT_LAST = '1;

    arb_state_e      r_state;
    arb_state_e      w_state_d;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   r_addr;
    logic            r_init_done;
    logic [NREQ-1:0] r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;
    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_rd_grant;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (r_state == StRun),
        .i_valid (i_req_valid),
        .o_grant (w_grant)
    );

    assign o_req_ready = w_grant;
    assign w_rd_grant  = w_grant & ~i_req_we;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_init_done = r_init_done;

    // Next state: leave INIT once the last address has been cleared.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StInit: if (r_cnt == CNT_LAST) w_state_d = StRun;
            StRun:  w_state_d = StRun;
        endcase
    end

    // RAM drive: clear sweep in INIT, granted requester in RUN, address held when idle.
    always_comb begin
        o_ram_we    = 1'b0;
        o_ram_addr  = r_addr;
        o_ram_wdata = '0;
        if (r_state == StInit) begin
            // Gated by reset so the RAM sees no write while reset is held.
            o_ram_we   = i_rst_n;
            o_ram_addr = r_cnt;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (w_grant[i]) begin
                    o_ram_we    = i_req_we[i];
                    o_ram_addr  = i_req_addr[i*AW +: AW];
                    o_ram_wdata = i_req_wdata[i*DW +: DW];
                end
            end
        end
    end

    // State, clear counter, held address and registered read return.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StInit;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_init_done <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_d;
            r_addr      <= o_ram_addr;
            r_rsp_valid <= w_rd_grant;
            if (r_state == StInit) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) r_init_done <= 1'b1;
            end
            if (|w_rd_grant) r_rsp_rdata <= i_ram_rdata;
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_grants [NREQ];
    logic [STAT_W-1:0] r_stat_conflicts;
    int unsigned       w_nvalid;
    logic              w_conflict;

    // Conflict = two or more requesters valid in the same cycle.
    always_comb begin
        w_nvalid = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_nvalid = w_nvalid + 32'(i_req_valid[i]);
        end
        w_conflict = (r_state == StRun) && (w_nvalid >= 2);
    end

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) r_stat_grants[i] <= '0;
            r_stat_conflicts <= '0;
        end else if (i_stat_clr) begin
            for (int unsigned i = 0; i < NREQ; i++) r_stat_grants[i] <= '0;
            r_stat_conflicts <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (w_grant[i] && r_stat_grants[i] != '1) begin
                    r_stat_grants[i] <= r_stat_grants[i] + 1'b1;
                end
            end
            if (w_conflict && r_stat_conflicts != '1) begin
                r_stat_conflicts <= r_stat_conflicts + 1'b1;
            end
        end
    end

    // Pack per-requester counters onto the flat output.
    always_comb begin
        o_stat_grants = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            o_stat_grants[i*STAT_W +: STAT_W] = r_stat_grants[i];
        end
    end

    assign o_stat_conflicts = r_stat_conflicts;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 64x8 RAM and a read-response scoreboard.
// Stats checks are included when RAM_ARB_STATS_EN is defined.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        init_done;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
`ifdef RAM_ARB_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_grants;
    logic [15:0] stat_conflicts;
`endif

    // Non-zero power-up contents so the clear sweep is observable.
    logic [7:0] mem [64] = '{default: 8'hFF};

    typedef struct packed {
        logic [1:0] who;
        logic [7:0] data;
    } rsp_t;

    rsp_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ram_port_arbiter #(
        .NREQ (2),
        .AW   (6),
        .DW   (8)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .i_req_we         (req_we),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_req_ready      (req_ready),
        .o_rsp_valid      (rsp_valid),
        .o_rsp_rdata      (rsp_rdata),
        .o_init_done      (init_done),
        .o_ram_we         (ram_we),
        .o_ram_addr       (ram_addr),
        .o_ram_wdata      (ram_wdata),
        .i_ram_rdata      (ram_rdata)
`ifdef RAM_ARB_STATS_EN
        ,
        .i_stat_clr       (stat_clr),
        .o_stat_grants    (stat_grants),
        .o_stat_conflicts (stat_conflicts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic v, input logic we,
                           input logic [5:0] a, input logic [7:0] d);
        req_valid[idx]          = v;
        req_we[idx]             = we;
        req_addr[idx*6 +: 6]    = a;
        req_wdata[idx*8 +: 8]   = d;
    endtask

    task automatic expect_rsp(input logic [1:0] who, input logic [7:0] d);
        rsp_t e;
        e.who  = who;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Settle, check the grant, and advance to the next falling edge.
    task automatic cyc(input string tag, input logic [1:0] exp_ready);
        #1;
        check(tag, 32'(req_ready), 32'(exp_ready));
        @(negedge clk);
    endtask

    // Checks n clear-sweep cycles from address 0, with both requesters pushing reads.
    task automatic run_init(input int n);
        req_valid = 2'b11;
        req_we    = 2'b00;
        for (int k = 0; k < n; k++) begin
            #1;
            check("init_we",    32'(ram_we),    1);
            check("init_addr",  32'(ram_addr),  32'(k));
            check("init_wdata", 32'(ram_wdata), 0);
            check("init_ready", 32'(req_ready), 0);
            check("init_done0", 32'(init_done), 0);
            @(negedge clk);
        end
        req_valid = 2'b00;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef RAM_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif

        // Response monitor: one pop per returned read, latency fixed at one cycle.
        fork
            begin
                forever begin
                    rsp_t e;
                    @(posedge clk);
                    #2;
                    if (rst_n) begin
                        if (sb_q.size() > 0) begin
                            e = sb_q.pop_front();
                            check("rsp_valid", 32'(rsp_valid), 32'(e.who));
                            check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                        end else if (rsp_valid != 2'b00) begin
                            check("rsp_unexpected", 32'(rsp_valid), 0);
                        end
                    end
                end
            end
        join_none

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rspv",  32'(rsp_valid), 0);
        check("rst_rdata", 32'(rsp_rdata), 0);
        check("rst_done",  32'(init_done), 0);
        check("rst_we",    32'(ram_we),    0);
        check("rst_addr",  32'(ram_addr),  0);
        check("rst_wdata", 32'(ram_wdata), 0);

        // Full clear sweep, then first RUN cycle.
        rst_n = 1'b1;
        run_init(64);
        #1;
        check("run_done",  32'(init_done), 1);
        check("idle_we",   32'(ram_we),    0);
        check("idle_hold", 32'(ram_addr),  63);

        // Read of a cleared location.
        set_req(0, 1'b1, 1'b0, 6'd5, 8'h00);
        expect_rsp(2'b01, 8'h00);
        cyc("rd5_ready", 2'b01);

        // Write then back-to-back read of the same address.
        set_req(0, 1'b1, 1'b1, 6'd3, 8'hA5);
        #1;
        check("wr_we",    32'(ram_we),    1);
        check("wr_wdata", 32'(ram_wdata), 'hA5);
        cyc("wr_ready", 2'b01);
        set_req(0, 1'b1, 1'b0, 6'd3, 8'h00);
        expect_rsp(2'b01, 8'hA5);
        cyc("rdback_ready", 2'b01);
        req_valid = 2'b00;

        // Move pointer to 0 with a lone req1 read, then rotate under full load.
        set_req(1, 1'b1, 1'b0, 6'd3, 8'h00);
        expect_rsp(2'b10, 8'hA5);
        cyc("p0_ready", 2'b10);
        set_req(0, 1'b1, 1'b0, 6'd3, 8'h00);
        set_req(1, 1'b1, 1'b0, 6'd5, 8'h00);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                expect_rsp(2'b01, 8'hA5);
                cyc("rot_ready", 2'b01);
            end else begin
                expect_rsp(2'b10, 8'h00);
                cyc("rot_ready", 2'b10);
            end
        end
        req_valid = 2'b00;

        // Pointer to 1, then same-cycle read/write of address 63.
        set_req(0, 1'b1, 1'b0, 6'd5, 8'h00);
        expect_rsp(2'b01, 8'h00);
        cyc("p1_ready", 2'b01);
        set_req(0, 1'b1, 1'b1, 6'd63, 8'h3C);
        set_req(1, 1'b1, 1'b0, 6'd63, 8'h00);
        expect_rsp(2'b10, 8'h00);
        cyc("col_r1_ready", 2'b10);
        req_valid[1] = 1'b0;
        #1;
        check("col_w_we",    32'(ram_we),    1);
        check("col_w_wdata", 32'(ram_wdata), 'h3C);
        cyc("col_w0_ready", 2'b01);
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, 6'd63, 8'h00);
        expect_rsp(2'b10, 8'h3C);
        cyc("col_rd_ready", 2'b10);
        req_valid = 2'b00;
        #1;
        check("nogrant_ready", 32'(req_ready), 0);
        check("nogrant_we",    32'(ram_we),    0);
        check("nogrant_hold",  32'(ram_addr),  63);
        @(negedge clk);

        // Reset in RUN with a read in flight: response must be dropped.
        set_req(0, 1'b1, 1'b0, 6'd63, 8'h00);
        #1;
        check("inflight_ready", 32'(req_ready), 'b01);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rrst_rspv",  32'(rsp_valid), 0);
        check("rrst_rdata", 32'(rsp_rdata), 0);
        check("rrst_ready", 32'(req_ready), 0);
        check("rrst_done",  32'(init_done), 0);
        check("rrst_we",    32'(ram_we),    0);
        check("rrst_addr",  32'(ram_addr),  0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset again partway through the clear sweep.
        run_init(20);
        #1;
        check("mid_addr20", 32'(ram_addr), 20);
        rst_n = 1'b0;
        #1;
        check("mid_rst_addr", 32'(ram_addr), 0);
        check("mid_rst_we",   32'(ram_we),   0);
        @(negedge clk);
        rst_n = 1'b1;
        run_init(64);

        // Earlier writes are wiped by the fresh clear.
        set_req(0, 1'b1, 1'b0, 6'd63, 8'h00);
        expect_rsp(2'b01, 8'h00);
        cyc("clr63_ready", 2'b01);
        set_req(0, 1'b1, 1'b0, 6'd3, 8'h00);
        expect_rsp(2'b01, 8'h00);
        cyc("clr3_ready", 2'b01);
        req_valid = 2'b00;

`ifdef RAM_ARB_STATS_EN
        // Pointer back to 0, clear counters, then five conflicting write cycles.
        set_req(1, 1'b1, 1'b1, 6'd10, 8'h11);
        cyc("st_p0_ready", 2'b10);
        req_valid = 2'b00;
        stat_clr  = 1'b1;
        @(negedge clk);
        stat_clr  = 1'b0;
        set_req(0, 1'b1, 1'b1, 6'd11, 8'h22);
        set_req(1, 1'b1, 1'b1, 6'd12, 8'h33);
        for (int k = 0; k < 5; k++) begin
            cyc("st_ready", (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        req_valid = 2'b00;
        #1;
        check("st_grant0",    32'(stat_grants[15:0]),  3);
        check("st_grant1",    32'(stat_grants[31:16]), 2);
        check("st_conflicts", 32'(stat_conflicts),     5);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        check("st_clr_grants",    32'(stat_grants),    0);
        check("st_clr_conflicts", 32'(stat_conflicts), 0);
        @(negedge clk);
`endif

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one 64x8 single-port RAM (write-enable, 6-bit address, 8-bit write data, combinational read data) among NREQ requesters.
- Round-robin arbitration: one RAM access per cycle.
- Zero-fills the RAM after reset before accepting traffic.
- Returns registered read data to the requester that issued the read.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 6, RAM address width; depth = 2**AW.
- DW, 8, RAM data width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester access request.
- req_we  in  NREQ  per-requester op: 1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; requester i at [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant; access accepted when valid & ready.
- rsp_valid  out  NREQ  one-hot read-return pulse.
- rsp_rdata  out  DW  read data, valid when any rsp_valid bit is set.
- init_done  out  1  high once RAM clear completes.
- ram_we  out  1  to RAM write enable.
- ram_addr  out  AW  to RAM address.
- ram_wdata  out  DW  to RAM write data.
- ram_rdata  in  DW  from RAM read data (combinational on ram_addr).

Behaviour:
- Reset values:
  - State = INIT, init counter = 0, rr pointer = 0.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, init_done = 0.
  - ram_we = 0, ram_addr = 0, ram_wdata = 0 (ram outputs combinational from state).
- INIT state:
  - Each cycle: ram_we = 1, ram_addr = counter, ram_wdata = 0; counter increments.
  - req_ready = 0 throughout.
  - At counter = 2**AW-1, the write completes and state moves to RUN next cycle.
  - Takes exactly 2**AW cycles; init_done registered high from the first RUN cycle and stays high.
- RUN state:
  - Grant search starts at rr pointer and walks upward with wrap-around (NREQ-1 -> 0); the first requester with valid = 1 wins.
  - req_ready is combinational from req_valid and the pointer: exactly one bit set if any valid, else 0.
  - Never assert ready to a requester whose valid = 0.
  - Granted cycle: ram_we = req_we[g], ram_addr = req_addr[g], ram_wdata = req_wdata[g].
  - No grant: ram_we = 0, ram_addr holds last value.
  - After a grant to g, rr pointer = (g+1) mod NREQ; unchanged when no grant.
- Read latency 1:
  - A read granted in cycle T samples ram_rdata at the end of T.
  - Next cycle: rsp_valid[g] = 1 for one cycle and rsp_rdata = sampled data.
  - Writes produce no response.
  - Responses have no backpressure; requesters must accept them.
- Back-to-back accesses allowed every cycle. A read in T+1 of an address written in T returns the new data.
- Requesters hold valid/we/addr/wdata stable until ready; dropping valid before grant is permitted (request withdrawn).
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0,...; any requester waits at most NREQ-1 cycles.
- Reset mid-operation (either state):
  - Asynchronously return to INIT; in-flight read response is dropped.
  - RAM clear restarts from address 0.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants (NREQ*16 bits): per-requester 16-bit grant counters, saturating at 16'hFFFF.
  - Adds output stat_conflicts (16 bits): saturating count of RUN cycles with two or more valids.
  - All counters reset to 0 and count only in RUN.
  - Adds input stat_clr (1 bit): synchronous clear of all counters; clear wins over a same-cycle increment.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum (INIT, RUN);
  - default AW/DW constants;
  - STAT_W = 16;
  - function rr_pick (valid vector, pointer -> one-hot grant).
- Sub-module rr_arbiter: pointer register plus grant logic, reusable by other shared-resource blocks.
- The RAM stays external, connected through the ram_* ports.

Test Plan:
- Reset, then idle 64 cycles -> ram_we = 1 with addresses 0..63 and wdata 0; init_done rises on cycle 65; req_ready stays 0 throughout; afterwards a read of addr 5 returns 8'h00.
- Req0 writes 8'hA5 to addr 3 at cycle T; req0 reads addr 3 at T+1 -> rsp_valid = 2'b01 at T+2 with rsp_rdata = 8'hA5.
- Both requesters valid continuously for 6 cycles, pointer at 0 -> req_ready sequence 01,10,01,10,01,10.
- Req1 read of addr 63 and req0 write of 8'h3C to addr 63 in the same cycle, pointer at 1 -> req1 granted and gets the old value; req0 granted next cycle; a later read returns 8'h3C.
- Assert rst_n low during INIT at counter 20 and during RUN with a read in flight -> outputs return to reset values immediately, no rsp_valid, clear restarts at addr 0.
- With RAM_ARB_STATS_EN: 5 conflicting cycles, then stat_clr -> stat_conflicts = 5 before the clear, 0 after; grant counters = 3 and 2 before the clear.
